// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode values and the glue FSM state encoding used by
// the UART/ALU glue stage.
package alu_pkg;

    localparam int SIZEDATA = 8;
    localparam int SIZEOP   = 6;

    localparam logic [SIZEOP-1:0] OP_ADD = 6'b100000;
    localparam logic [SIZEOP-1:0] OP_SUB = 6'b100010;
    localparam logic [SIZEOP-1:0] OP_AND = 6'b100100;
    localparam logic [SIZEOP-1:0] OP_OR  = 6'b100101;
    localparam logic [SIZEOP-1:0] OP_XOR = 6'b100110;
    localparam logic [SIZEOP-1:0] OP_NOR = 6'b100111;
    localparam logic [SIZEOP-1:0] OP_SRA = 6'b000011;
    localparam logic [SIZEOP-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_COMPUTE) || (s == ST_SEND) || (s == ST_WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Counts idle clocks between received bytes; o_expire flags the last allowed
// idle clock of a partial triplet.
module uart_gap_timer #(
    parameter int TIMEOUT_CLKS = 2000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    logic [CW-1:0] r_count;

    assign o_expire = i_enable && (r_count == CW'(TIMEOUT_CLKS - 1));

    // Holds at the terminal value; the FSM clears it on the way back to WAIT_A.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Glue between UART RX/TX and a combinational ALU: gathers A, B and opcode,
// latches the ALU result, starts a TX frame and waits for it to complete.
module uart_alu_interface
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 2000000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [SIZEDATA-1:0] i_rx_data,
    input  logic [SIZEDATA-1:0] i_alu_result,
    input  logic                i_tx_done,
    output logic [SIZEDATA-1:0] o_operand_a,
    output logic [SIZEDATA-1:0] o_operand_b,
    output logic [SIZEOP-1:0]   o_opcode,
    output logic                o_tx_signal,
    output logic [SIZEDATA-1:0] o_tx_result,
    output logic                o_busy,
    output logic                o_overrun,
    output logic                o_timeout
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_overrun;
    logic                w_timeout;
    logic                w_expire;
    logic                w_gap_enable;
    logic                w_gap_clear;
    logic [SIZEDATA-1:0] r_operand_a;
    logic [SIZEDATA-1:0] r_operand_b;
    logic [SIZEOP-1:0]   r_opcode;
    logic [SIZEDATA-1:0] r_tx_result;
    logic                r_tx_signal;
    logic                r_busy;
    logic                r_overrun;
    logic                r_timeout;

    assign w_gap_enable = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_gap_clear  = i_rx_done || (w_state_next == ST_WAIT_A);

    uart_gap_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_gap_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_gap_clear),
        .i_enable (w_gap_enable),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A byte arriving on the expiry clock takes priority over the timeout.
    always_comb begin
        w_state_next = r_state;
        w_overrun    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_WAIT_A: begin
                if (i_rx_done) w_state_next = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    w_state_next = ST_WAIT_OP;
                end else if (w_expire) begin
                    w_state_next = ST_WAIT_A;
                    w_timeout    = 1'b1;
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    w_state_next = ST_COMPUTE;
                end else if (w_expire) begin
                    w_state_next = ST_WAIT_A;
                    w_timeout    = 1'b1;
                end
            end
            ST_COMPUTE: begin
                w_state_next = ST_SEND;
                w_overrun    = i_rx_done;
            end
            ST_SEND: begin
                w_state_next = ST_WAIT_TX;
                w_overrun    = i_rx_done;
            end
            ST_WAIT_TX: begin
                w_overrun = i_rx_done;
                if (i_tx_done) w_state_next = ST_WAIT_A;
            end
            default: begin
                w_state_next = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_opcode    <= '0;
            r_tx_result <= '0;
            r_tx_signal <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_A && i_rx_done) r_operand_a <= i_rx_data;
            if (r_state == ST_WAIT_B && i_rx_done) r_operand_b <= i_rx_data;
            if (r_state == ST_WAIT_OP && i_rx_done) r_opcode <= i_rx_data[SIZEOP-1:0];
            if (r_state == ST_COMPUTE) r_tx_result <= i_alu_result;
            r_tx_signal <= (w_state_next == ST_SEND);
            r_busy      <= is_busy_state(w_state_next);
            r_overrun   <= w_overrun;
            r_timeout   <= w_timeout;
        end
    end

    assign o_operand_a = r_operand_a;
    assign o_operand_b = r_operand_b;
    assign o_opcode    = r_opcode;
    assign o_tx_result = r_tx_result;
    assign o_tx_signal = r_tx_signal;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed plus randomized bench for uart_alu_interface with a behavioural
// ALU and an expected-result model computed from the bytes sent.
module tb_uart_alu_interface;
    import alu_pkg::*;

    localparam int T = 16;

    logic                i_clock = 1'b0;
    logic                i_reset = 1'b0;
    logic                i_rx_done = 1'b0;
    logic [SIZEDATA-1:0] i_rx_data = '0;
    logic [SIZEDATA-1:0] i_alu_result;
    logic                i_tx_done = 1'b0;
    logic [SIZEDATA-1:0] o_operand_a;
    logic [SIZEDATA-1:0] o_operand_b;
    logic [SIZEOP-1:0]   o_opcode;
    logic                o_tx_signal;
    logic [SIZEDATA-1:0] o_tx_result;
    logic                o_busy;
    logic                o_overrun;
    logic                o_timeout;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] ops [8];

    always #5 i_clock = ~i_clock;

    uart_alu_interface #(.TIMEOUT_CLKS(T)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_operand_a  (o_operand_a),
        .o_operand_b  (o_operand_b),
        .o_opcode     (o_opcode),
        .o_tx_signal  (o_tx_signal),
        .o_tx_result  (o_tx_result),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun),
        .o_timeout    (o_timeout)
    );

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic [7:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SRA:  r = $signed(a) >>> b;
            OP_SRL:  r = a >> b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb i_alu_result = alu_ref(o_operand_a, o_operand_b, o_opcode);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {o_operand_a, o_operand_b, o_opcode, o_tx_signal, o_tx_result,
                    o_busy, o_overrun, o_timeout}, 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge i_clock);
        @(negedge i_clock);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clock);
        i_rx_done = 1'b0;
    endtask

    task automatic tx_done_pulse();
        @(negedge i_clock);
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_tx_done = 1'b0;
    endtask

    // Sends a triplet and checks the TX handshake; optionally completes the TX frame.
    task automatic run_triplet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                               input int gap, input bit finish_tx);
        logic [7:0] exp;
        exp = alu_ref(a, b, op[5:0]);
        send_byte(a, gap);
        send_byte(b, gap);
        send_byte(op, gap);
        check("busy_compute", o_busy, 1);
        check("tx_sig_compute", o_tx_signal, 0);
        @(negedge i_clock);
        check("tx_signal", o_tx_signal, 1);
        check("tx_result", o_tx_result, exp);
        check("operands", {o_operand_a, o_operand_b, o_opcode}, {a, b, op[5:0]});
        @(negedge i_clock);
        check("tx_signal_once", o_tx_signal, 0);
        check("busy_wait_tx", o_busy, 1);
        check("result_held", o_tx_result, exp);
        $display("triplet a=%02h b=%02h op=%02h -> expected %02h got %02h", a, b, op, exp, o_tx_result);
        if (finish_tx) begin
            repeat (2) @(negedge i_clock);
            tx_done_pulse();
            check("busy_released", o_busy, 0);
        end
    endtask

    initial begin
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

        repeat (2) @(negedge i_clock);
        check_all_zero("reset_hold");
        i_reset = 1'b1;
        @(negedge i_clock);
        check_all_zero("after_reset");

        run_triplet(8'h04, 8'h08, 8'h20, 0, 1);
        run_triplet(8'h04, 8'h08, 8'h22, 0, 1);
        run_triplet(8'h80, 8'h01, 8'h03, 0, 1);
        run_triplet(8'h04, 8'h08, 8'hE5, 0, 1);
        check("opcode_masked", o_opcode, 6'b100101);

        // Partial triplet abort after T idle clocks; operand A is kept.
        send_byte(8'h04, 0);
        check("busy_wait_b", o_busy, 0);
        repeat (T - 1) @(negedge i_clock);
        check("timeout_early", o_timeout, 0);
        @(negedge i_clock);
        check("timeout_pulse", o_timeout, 1);
        check("operand_kept", o_operand_a, 8'h04);
        @(negedge i_clock);
        check("timeout_single", o_timeout, 0);
        $display("timeout after byte 04 observed");
        run_triplet(8'h01, 8'h02, 8'h20, 0, 1);

        // Byte arriving on the expiry clock wins over the timeout.
        send_byte(8'h11, 0);
        repeat (T - 2) @(negedge i_clock);
        send_byte(8'h22, 0);
        check("byte_wins", o_timeout, 0);
        send_byte(8'h20, 0);
        check("boundary_busy", o_busy, 1);
        @(negedge i_clock);
        check("boundary_tx", {o_tx_signal, o_tx_result}, {1'b1, 8'h33});
        $display("boundary byte accepted, result %02h", o_tx_result);
        @(negedge i_clock);
        tx_done_pulse();

        // Overrun while waiting for TX.
        run_triplet(8'h10, 8'h20, 8'h26, 0, 0);
        send_byte(8'h55, 0);
        check("overrun_pulse", o_overrun, 1);
        check("overrun_busy", o_busy, 1);
        @(negedge i_clock);
        check("overrun_single", o_overrun, 0);
        tx_done_pulse();
        check("overrun_release", o_busy, 0);
        run_triplet(8'h0F, 8'h01, 8'h02, 0, 1);

        // Byte and TX completion together: byte dropped, back to WAIT_A.
        run_triplet(8'hF0, 8'h0F, 8'h27, 0, 0);
        @(negedge i_clock);
        i_rx_data = 8'h77;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check("simul_overrun", o_overrun, 1);
        check("simul_idle", o_busy, 0);
        tx_done_pulse();
        check("stray_tx_done", o_busy, 0);
        run_triplet(8'h33, 8'h0F, 8'h24, 0, 1);

        // Reset during WAIT_OP.
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 i_reset = 1'b0;
        #1 check_all_zero("reset_wait_op");
        @(negedge i_clock);
        i_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clock);
            check("post_reset_quiet", {o_tx_signal, o_busy}, 2'b00);
        end
        $display("reset in WAIT_OP handled");

        // Reset during SEND cancels the start pulse.
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        @(negedge i_clock);
        check("send_before_reset", o_tx_signal, 1);
        #1 i_reset = 1'b0;
        #1 check_all_zero("reset_send");
        @(negedge i_clock);
        i_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clock);
            check("no_tx_after_reset", {o_tx_signal, o_busy}, 2'b00);
        end
        $display("reset in SEND handled");

        for (int n = 0; n < 24; n++) begin
            logic [7:0] ra, rb, rop;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = {2'($urandom), ops[$urandom_range(0, 7)]};
            run_triplet(ra, rb, rop, int'($urandom_range(0, T - 3)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
